// File: rtl/prio_encoder_hs.sv
// prio_encoder_hs
//   Registered priority encoder with sticky request capture and a valid/ready
//   output. Request lines are sampled into a pending register; one pending
//   index is issued per handshake, chosen either by fixed priority (index N-1
//   highest) or round-robin (most recently granted index becomes lowest).
//
// Parameters
//   N          number of request lines (2..64)
//   IDX_W      index width, 2**IDX_W >= N
//   ACTIVE_LOW 1: a req bit of 0 means requesting; 0: a req bit of 1 means requesting
//   RR_MODE    0: fixed priority; 1: round-robin
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   en         1: sample req this cycle
//   req        request lines (polarity per ACTIVE_LOW)
//   out_ready  consumer accepts out_idx when out_valid && out_ready
//   out_valid  out_idx/out_code hold a granted request
//   out_idx    granted index
//   out_code   out_valid ? out_idx+1 : 0
//   pending    captured, not yet issued requests (active-high)
//   overrun    one-cycle pulse: a sampled request hit an already-pending bit
module prio_encoder_hs #(
  parameter int N          = 8,
  parameter int IDX_W      = 3,
  parameter int ACTIVE_LOW = 1,
  parameter int RR_MODE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_code,
  output logic [N-1:0]     pending,
  output logic             overrun
);

  logic [N-1:0]     req_h;
  logic [N-1:0]     sampled;
  logic [N-1:0]     win_oh;
  logic [N-1:0]     clr;
  logic             load;
  logic             any_pend;
  logic             grant;
  logic [IDX_W-1:0] last;
  logic [IDX_W-1:0] hi_idx;
  logic [IDX_W-1:0] lo_idx;
  logic             lo_found;
  logic [IDX_W-1:0] win_idx;

  // Request capture: normalise polarity and gate with en.
  assign req_h    = (ACTIVE_LOW != 0) ? ~req : req;
  assign sampled  = en ? req_h : '0;
  assign load     = !out_valid || out_ready;
  assign any_pend = |pending;
  assign grant    = load && any_pend;

  // Winner selection from the current pending set only.
  // hi_idx is the highest pending index overall. lo_idx is the highest pending
  // index strictly below the round-robin pointer; a descending search that
  // starts at last-1 and wraps finds lo_idx if one exists, otherwise hi_idx.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    lo_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (pending[i]) begin
        hi_idx = IDX_W'(i);
        if (IDX_W'(i) < last) begin
          lo_idx   = IDX_W'(i);
          lo_found = 1'b1;
        end
      end
    end
    if ((RR_MODE != 0) && lo_found) begin
      win_idx = lo_idx;
    end else begin
      win_idx = hi_idx;
    end
  end

  always_comb begin
    win_oh = '0;
    for (int i = 0; i < N; i++) begin
      win_oh[i] = (IDX_W'(i) == win_idx);
    end
  end

  assign clr = grant ? win_oh : '0;

  // Output / pending register stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      pending   <= '0;
      overrun   <= 1'b0;
      last      <= '0;
    end else begin
      if (load) begin
        out_valid <= any_pend;
        if (any_pend) begin
          out_idx <= win_idx;
          last    <= win_idx;
        end
      end
      // A bit cleared by this grant and re-sampled on the same edge stays set.
      pending <= (pending & ~clr) | sampled;
      overrun <= |(sampled & pending & ~clr);
    end
  end

  // out_code is derived from registered state only, so no input reaches it.
  assign out_code = out_valid ? ({1'b0, out_idx} + (IDX_W+1)'(1)) : '0;

endmodule

// File: tb/tb_prio_encoder_hs.sv
module tb_prio_encoder_hs;
  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         en = 1'b0;
  logic [N-1:0] req = '1;
  logic         out_ready = 1'b1;

  logic         f_valid, r_valid, f_over, r_over;
  logic [W-1:0] f_idx, r_idx;
  logic [W:0]   f_code, r_code;
  logic [N-1:0] f_pend, r_pend;

  int total = 0;
  int bad = 0;
  bit cmp_on = 1'b0;

  always #5 clk = ~clk;

  prio_encoder_hs #(.N(N), .IDX_W(W), .ACTIVE_LOW(1), .RR_MODE(0)) u_fix (
    .clk(clk), .reset(reset), .en(en), .req(req), .out_ready(out_ready),
    .out_valid(f_valid), .out_idx(f_idx), .out_code(f_code),
    .pending(f_pend), .overrun(f_over));

  prio_encoder_hs #(.N(N), .IDX_W(W), .ACTIVE_LOW(1), .RR_MODE(1)) u_rr (
    .clk(clk), .reset(reset), .en(en), .req(req), .out_ready(out_ready),
    .out_valid(r_valid), .out_idx(r_idx), .out_code(r_code),
    .pending(r_pend), .overrun(r_over));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending set as a bit vector, winner found by walking indices.
  function automatic int fixed_win(input logic [N-1:0] p);
    int r = 0;
    bit f = 1'b0;
    for (int j = N-1; j >= 0; j--) begin
      if (!f && p[j]) begin
        r = j;
        f = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic int rr_win(input logic [N-1:0] p, input int last);
    int r = 0;
    int j;
    bit f = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (last - k + N) % N;
      if (!f && p[j]) begin
        r = j;
        f = 1'b1;
      end
    end
    return r;
  endfunction

  logic [N-1:0] mp_f, mp_r;
  logic         mv_f, mv_r, mo_f, mo_r;
  int           mi_f, mi_r, ml_r;
  logic [N-1:0] smp, clr_f, clr_r;
  logic         gf, gr;

  assign smp   = en ? ~req : '0;
  assign gf    = (!mv_f || out_ready) && (mp_f != 0);
  assign gr    = (!mv_r || out_ready) && (mp_r != 0);
  assign clr_f = gf ? (N'(1) << fixed_win(mp_f)) : '0;
  assign clr_r = gr ? (N'(1) << rr_win(mp_r, ml_r)) : '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mp_f <= '0; mv_f <= 1'b0; mi_f <= 0; mo_f <= 1'b0;
      mp_r <= '0; mv_r <= 1'b0; mi_r <= 0; mo_r <= 1'b0; ml_r <= 0;
    end else begin
      if (gf) begin
        mv_f <= 1'b1;
        mi_f <= fixed_win(mp_f);
      end else if (!mv_f || out_ready) begin
        mv_f <= 1'b0;
      end
      mp_f <= (mp_f & ~clr_f) | smp;
      mo_f <= |(smp & mp_f & ~clr_f);
      if (gr) begin
        mv_r <= 1'b1;
        mi_r <= rr_win(mp_r, ml_r);
        ml_r <= rr_win(mp_r, ml_r);
      end else if (!mv_r || out_ready) begin
        mv_r <= 1'b0;
      end
      mp_r <= (mp_r & ~clr_r) | smp;
      mo_r <= |(smp & mp_r & ~clr_r);
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("fix_valid", f_valid, mv_f);
      chk("fix_idx",   f_idx,   mi_f);
      chk("fix_code",  f_code,  mv_f ? mi_f + 1 : 0);
      chk("fix_pend",  f_pend,  mp_f);
      chk("fix_over",  f_over,  mo_f);
      chk("rr_valid",  r_valid, mv_r);
      chk("rr_idx",    r_idx,   mi_r);
      chk("rr_code",   r_code,  mv_r ? mi_r + 1 : 0);
      chk("rr_pend",   r_pend,  mp_r);
      chk("rr_over",   r_over,  mo_r);
    end
  end

  // Drive inputs at a negedge, then advance to the next negedge.
  task automatic step(input bit e, input logic [N-1:0] reqh, input bit rdy);
    en = e;
    req = ~reqh;
    out_ready = rdy;
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    en = 1'b0;
    req = '1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cmp_on = 1'b1;
    chk("rst_valid", f_valid, 0);
    chk("rst_idx",   f_idx,   0);
    chk("rst_code",  f_code,  0);
    chk("rst_pend",  f_pend,  0);
    chk("rst_over",  f_over,  0);

    // Fixed priority drain of 8'h90
    step(1'b1, 8'h90, 1'b1);
    chk("t1_pend", f_pend, 8'h90);
    chk("t1_valid0", f_valid, 0);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_idx7", f_idx, 7);
    chk("t1_code8", f_code, 8);
    chk("t1_pend10", f_pend, 8'h10);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_idx4", f_idx, 4);
    chk("t1_code5", f_code, 5);
    chk("t1_pend0", f_pend, 0);
    step(1'b0, 8'h00, 1'b1);
    chk("t1_done", f_valid, 0);
    chk("t1_code0", f_code, 0);

    // Backpressure holds the output
    step(1'b1, 8'h90, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    for (int k = 0; k < N; k++) begin
      step(1'b0, 8'h00, 1'b0);
      chk("t2_hold_idx", f_idx, 7);
      chk("t2_hold_valid", f_valid, 1);
      chk("t2_hold_pend", f_pend, 8'h10);
    end
    step(1'b0, 8'h00, 1'b1);
    chk("t2_idx4", f_idx, 4);
    step(1'b0, 8'h00, 1'b1);

    // Round-robin versus fixed with every line requesting
    rst_pulse();
    step(1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 18; k++) begin
      step(1'b1, 8'hFF, 1'b1);
      chk("t3_rr_idx", r_idx, 7 - (k % 8));
      chk("t3_fix_idx", f_idx, 7);
    end

    // Overrun on a pending, ungranted bit
    rst_pulse();
    step(1'b1, 8'h88, 1'b1);
    step(1'b1, 8'h08, 1'b0);
    chk("t4_over1", f_over, 1);
    chk("t4_idx7", f_idx, 7);
    chk("t4_pend08", f_pend, 8'h08);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_over0", f_over, 0);
    chk("t4_idx3", f_idx, 3);
    chk("t4_pend0", f_pend, 0);
    step(1'b0, 8'h00, 1'b1);
    chk("t4_single", f_valid, 0);

    // Clear and resample on the same edge
    rst_pulse();
    step(1'b1, 8'h04, 1'b1);
    step(1'b1, 8'h04, 1'b1);
    chk("t5_idx2", f_idx, 2);
    chk("t5_pend04", f_pend, 8'h04);
    chk("t5_over0", f_over, 0);
    step(1'b0, 8'h00, 1'b1);
    chk("t5_again_valid", f_valid, 1);
    chk("t5_again_idx", f_idx, 2);
    chk("t5_pend0", f_pend, 0);
    step(1'b0, 8'h00, 1'b1);

    // Asynchronous reset between clock edges
    rst_pulse();
    step(1'b1, 8'hFF, 1'b0);
    step(1'b1, 8'hFF, 1'b0);
    chk("t6_pre_valid", f_valid, 1);
    chk("t6_pre_pend", f_pend, 8'hFF);
    en = 1'b0;
    req = '1;
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", f_valid, 0);
    chk("t6_idx", f_idx, 0);
    chk("t6_code", f_code, 0);
    chk("t6_pend", f_pend, 0);
    chk("t6_over", f_over, 0);
    chk("t6_rr_valid", r_valid, 0);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("t6_idle", f_valid, 0);
    end

    // Randomised traffic with occasional resets
    for (int k = 0; k < 800; k++) begin
      reset = ($urandom_range(0, 99) == 0);
      step(($urandom_range(0, 3) != 0), N'($urandom & $urandom), ($urandom_range(0, 2) != 0));
    end
    reset = 1'b0;
    step(1'b0, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
